// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin write-back arbiter driving two registered result buses from per-requester FIFOs; define CDB_BYPASS_EN for same-cycle bypass of empty FIFOs
module cdb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DEPTH = 2,
  parameter int TAG_W = 6,
  parameter int DATA_W = 32,
  parameter logic [TAG_W-1:0] TAG_FREE = '0,
  parameter logic [DATA_W-1:0] DATA_FREE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         reqValid,
  input  logic [NUM_REQ*TAG_W-1:0]   reqTag,
  input  logic [NUM_REQ*DATA_W-1:0]  reqData,
  output logic [NUM_REQ-1:0]         reqReady,
  output logic                       enWrtO,
  output logic                       enWrtT,
  output logic [TAG_W-1:0]           WrtTagO,
  output logic [TAG_W-1:0]           WrtTagT,
  output logic [DATA_W-1:0]          WrtDataO,
  output logic [DATA_W-1:0]          WrtDataT,
  output logic [1:0]                 busyCnt
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int RW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [TAG_W-1:0]  mem_tag   [NUM_REQ][DEPTH];
  logic [DATA_W-1:0] mem_data  [NUM_REQ][DEPTH];
  logic [PW-1:0]     rp        [NUM_REQ];
  logic [PW-1:0]     wp        [NUM_REQ];
  logic [CW-1:0]     cnt       [NUM_REQ];
  logic [TAG_W-1:0]  head_tag  [NUM_REQ];
  logic [DATA_W-1:0] head_data [NUM_REQ];
  logic [NUM_REQ-1:0] cand, gnt, push, pop;
  logic [RW-1:0] rr_ptr, sel_o, sel_t, last, rr_next;
  logic has_o, has_t, bus_o, bus_t;
  int scan_idx;
  assign bus_o = has_o & ~flush;
  assign bus_t = has_t & ~flush;
  // per-requester readiness, head view and candidacy; an empty FIFO presents the live request as its head
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqReady[i]  = (cnt[i] < CW'(DEPTH)) & ~flush;
      head_tag[i]  = |cnt[i] ? mem_tag[i][rp[i]]  : reqTag[i*TAG_W +: TAG_W];
      head_data[i] = |cnt[i] ? mem_data[i][rp[i]] : reqData[i*DATA_W +: DATA_W];
`ifdef CDB_BYPASS_EN
      cand[i] = |cnt[i] | (reqValid[i] & ~flush);
`else
      cand[i] = |cnt[i];
`endif
    end
  end
  // round-robin scan from rr_ptr: first candidate takes bus O, second takes bus T
  always_comb begin
    gnt = '0;
    has_o = 1'b0;
    has_t = 1'b0;
    sel_o = '0;
    sel_t = '0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (cand[scan_idx] && !has_o) begin
        has_o = 1'b1;
        sel_o = RW'(scan_idx);
        gnt[scan_idx] = 1'b1;
      end else if (cand[scan_idx] && !has_t) begin
        has_t = 1'b1;
        sel_t = RW'(scan_idx);
        gnt[scan_idx] = 1'b1;
      end
    end
    last = has_t ? sel_t : sel_o;
    rr_next = last == RW'(NUM_REQ - 1) ? '0 : last + RW'(1);
  end
  // a granted empty FIFO was served by bypass, so its request is not also stored
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pop[i]  = gnt[i] & |cnt[i];
      push[i] = reqValid[i] & reqReady[i] & rdy & ~(gnt[i] & ~|cnt[i]);
    end
  end
  // FIFO storage carries no reset; occupancy is tracked by cnt
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++)
      if (push[i]) begin
        mem_tag[i][wp[i]]  <= reqTag[i*TAG_W +: TAG_W];
        mem_data[i][wp[i]] <= reqData[i*DATA_W +: DATA_W];
      end
  end
  // FIFO pointers, counts, round-robin pointer and registered buses; everything holds while rdy is low
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i] <= '0;
        rp[i]  <= '0;
        wp[i]  <= '0;
      end
      rr_ptr   <= '0;
      enWrtO   <= 1'b0;
      enWrtT   <= 1'b0;
      WrtTagO  <= TAG_FREE;
      WrtTagT  <= TAG_FREE;
      WrtDataO <= DATA_FREE;
      WrtDataT <= DATA_FREE;
      busyCnt  <= 2'd0;
    end else if (rdy) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i] <= flush ? '0 : cnt[i] + CW'(push[i]) - CW'(pop[i]);
        rp[i]  <= flush ? '0 : rp[i] + PW'(pop[i]);
        wp[i]  <= flush ? '0 : wp[i] + PW'(push[i]);
      end
      if (bus_o) rr_ptr <= rr_next;
      enWrtO   <= bus_o;
      enWrtT   <= bus_t;
      WrtTagO  <= bus_o ? head_tag[sel_o]  : TAG_FREE;
      WrtTagT  <= bus_t ? head_tag[sel_t]  : TAG_FREE;
      WrtDataO <= bus_o ? head_data[sel_o] : DATA_FREE;
      WrtDataT <= bus_t ? head_data[sel_t] : DATA_FREE;
      busyCnt  <= {bus_o & bus_t, bus_o ^ bus_t};
    end
  end
endmodule
